traffic_phase_ctrl: RTL and testbench

- Phase sequencer for a two-way (NS/EW) intersection.
- Drives one external down-count timer (start / load / done handshake) to time each phase.
- Decodes lamp outputs, services latched pedestrian requests, and forces all-red on emergency.
- Sits between the timer and the lamp/IO drivers.

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/traffic_phase_ctrl.sv | 112 +++++++++++
 tb/tb_traffic_phase_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase sequencer: phase states,
// lamp patterns {red,yellow,green} and the direction of the next green.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    ALL_RED   = 3'd4,
    PED_WALK  = 3'd5,
    EMG_HOLD  = 3'd6
  } state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer. Each phase is timed by an external
// down-counter loaded with a one-cycle timer_start pulse on the phase entry.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ped_req,
  input  logic             emerg,
  input  logic             timer_done,
  output logic             timer_start,
  output logic [WIDTH-1:0] timer_load,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_pending,
  output logic [2:0]       phase
);

  state_e state_q, state_d;
  dir_e   dir_q, dir_d;
  logic   ped_q, ped_d;
  logic   entry_q, entry_d;
  logic   emg_lat_q, emg_lat_d;
  logic   expire, emg_hit;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    // timer_done in the entry cycle still belongs to the previous phase
    expire  = !entry_q && timer_done;
    emg_hit = emerg || emg_lat_q;
    case (state_q)
      NS_GREEN:  if (emerg || expire) state_d = NS_YELLOW;
      EW_GREEN:  if (emerg || expire) state_d = EW_YELLOW;
      NS_YELLOW: if (expire) begin
        dir_d   = DIR_EW;
        state_d = emg_hit ? EMG_HOLD : ALL_RED;
      end
      EW_YELLOW: if (expire) begin
        dir_d   = DIR_NS;
        state_d = emg_hit ? EMG_HOLD : ALL_RED;
      end
      ALL_RED: if (expire) begin
        if (emg_hit)            state_d = EMG_HOLD;
        else if (ped_q)         state_d = PED_WALK;
        else if (dir_q == DIR_NS) state_d = NS_GREEN;
        else                    state_d = EW_GREEN;
      end
      PED_WALK: begin
        if (emerg)       state_d = EMG_HOLD;
        else if (expire) state_d = ALL_RED;
      end
      EMG_HOLD: if (!emerg) state_d = ALL_RED;
      default:  state_d = ALL_RED;
    endcase
    // an emergency seen during a yellow/clearance phase is remembered until it ends
    emg_lat_d = (state_d == state_q) ? emg_hit : 1'b0;
    entry_d   = (state_d != state_q);
    ped_d     = (ped_q || ped_req) && !(state_d == PED_WALK && state_q != PED_WALK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ALL_RED;
      dir_q     <= DIR_NS;
      ped_q     <= 1'b0;
      entry_q   <= 1'b1;
      emg_lat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      ped_q     <= ped_d;
      entry_q   <= entry_d;
      emg_lat_q <= emg_lat_d;
    end
  end

  always_comb begin
    timer_start = entry_q && !reset && (state_q != EMG_HOLD);
    timer_load  = '0;
    ns_light    = LAMP_RED;
    ew_light    = LAMP_RED;
    walk        = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = LAMP_GRN;
      NS_YELLOW: ns_light = LAMP_YEL;
      EW_GREEN:  ew_light = LAMP_GRN;
      EW_YELLOW: ew_light = LAMP_YEL;
      PED_WALK:  walk     = 1'b1;
      default:   ;
    endcase
    if (timer_start) begin
      case (state_q)
        NS_GREEN, EW_GREEN:   timer_load = WIDTH'(T_GREEN);
        NS_YELLOW, EW_YELLOW: timer_load = WIDTH'(T_YELLOW);
        PED_WALK:             timer_load = WIDTH'(T_WALK);
        default:              timer_load = WIDTH'(T_ALLRED);
      endcase
    end
  end

  assign ped_pending = ped_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a behavioural down-count timer
// (phase length = load+2) and continuous lamp-safety monitoring.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int TG = 5, TY = 2, TA = 1, TW = 3;

  logic       clk = 1'b0;
  logic       reset, ped_req, emerg, timer_done;
  logic       timer_start, walk, ped_pending;
  logic [7:0] timer_load;
  logic [2:0] ns_light, ew_light, phase;
  logic [7:0] tcnt;

  int total = 0;
  int bad   = 0;
  int row   = -1;
  bit mon_en = 1'b0;
  logic [2:0] prev_ph = 3'd4;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .WIDTH(8), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW)
  ) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .emerg(emerg),
    .timer_done(timer_done), .timer_start(timer_start), .timer_load(timer_load),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .ped_pending(ped_pending), .phase(phase)
  );

  // down-count timer model
  always_ff @(posedge clk) begin
    if (reset)            tcnt <= '0;
    else if (timer_start) tcnt <= timer_load;
    else if (tcnt != 0)   tcnt <= tcnt - 8'd1;
  end
  assign timer_done = (tcnt == 8'd0);

  typedef struct {
    logic [2:0] ph;
    int         c0;
    int         len;
    int         load;
    int         ped_at;
    bit         pend;
  } rec_t;

  rec_t tbl[$];

  function automatic rec_t mk(logic [2:0] ph, int c0, int len, int load, int ped_at, bit pend);
    rec_t r;
    r.ph = ph; r.c0 = c0; r.len = len; r.load = load; r.ped_at = ped_at; r.pend = pend;
    return r;
  endfunction

  function automatic logic [2:0] exp_ns(logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(logic [2:0] ph);
    case (ph)
      3'd2:    return 3'b001;
      3'd3:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp, int cyc);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d cyc=%0d got=%0d want=%0d", nm, row, cyc, act, exp);
    end
  endtask

  task automatic run_phase(rec_t r);
    for (int c = r.c0; c < r.len; c++) begin
      if (c == r.ped_at) ped_req = 1'b1;
      #1;
      chk("phase", int'(phase), int'(r.ph), c);
      chk("timer_start", int'(timer_start), (c == 0 && r.ph != 3'd6) ? 1 : 0, c);
      chk("timer_load", int'(timer_load), (c == 0 && r.ph != 3'd6) ? r.load : 0, c);
      chk("ns_light", int'(ns_light), int'(exp_ns(r.ph)), c);
      chk("ew_light", int'(ew_light), int'(exp_ew(r.ph)), c);
      chk("walk", int'(walk), (r.ph == 3'd5) ? 1 : 0, c);
      if (c == r.len - 1) chk("ped_pending", int'(ped_pending), int'(r.pend), c);
      @(posedge clk); #1;
      ped_req = 1'b0;
    end
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      row = i;
      run_phase(tbl[i]);
    end
    tbl.delete();
  endtask

  // safety: no dual green, greens only entered from all-red clearance
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      total++;
      if (ns_light == 3'b001 && ew_light == 3'b001) begin
        bad++;
        $display("FAIL dual_green ns=%b ew=%b", ns_light, ew_light);
      end
      if (phase != prev_ph && (phase == 3'd0 || phase == 3'd2) && prev_ph != 3'd4) begin
        bad++;
        $display("FAIL green_entry from=%0d to=%0d want_from=4", prev_ph, phase);
      end
      prev_ph <= phase;
    end
  end

  initial begin
    reset = 1'b1; ped_req = 1'b0; emerg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", int'(phase), 4, 0);
    chk("rst_ns", int'(ns_light), 4, 0);
    chk("rst_ew", int'(ew_light), 4, 0);
    chk("rst_start", int'(timer_start), 0, 0);
    chk("rst_load", int'(timer_load), 0, 0);
    chk("rst_walk", int'(walk), 0, 0);
    chk("rst_pend", int'(ped_pending), 0, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // free run, then two pedestrian cycles (second one requested on the walk-entry edge)
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd0, 0, 7, TG, -1, 0));
    tbl.push_back(mk(3'd1, 0, 4, TY, -1, 0));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd2, 0, 7, TG, -1, 0));
    tbl.push_back(mk(3'd3, 0, 4, TY, -1, 0));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd0, 0, 7, TG,  1, 1));
    tbl.push_back(mk(3'd1, 0, 4, TY, -1, 1));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 1));
    tbl.push_back(mk(3'd5, 0, 5, TW, -1, 0));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd2, 0, 7, TG, -1, 0));
    tbl.push_back(mk(3'd3, 0, 4, TY, -1, 0));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd0, 0, 7, TG,  3, 1));
    tbl.push_back(mk(3'd1, 0, 4, TY, -1, 1));
    tbl.push_back(mk(3'd4, 0, 3, TA,  2, 1));
    tbl.push_back(mk(3'd5, 0, 5, TW, -1, 0));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd2, 0, 3, TG, -1, 0));
    run_tbl();

    // emergency at cycle 3 of EW green: abort to yellow, yellow completes, hold
    emerg = 1'b1;
    tbl.push_back(mk(3'd2, 3, 4, TG, -1, 0));
    tbl.push_back(mk(3'd3, 0, 4, TY, -1, 0));
    tbl.push_back(mk(3'd6, 0, 10, 0, -1, 0));
    run_tbl();
    emerg = 1'b0;
    tbl.push_back(mk(3'd6, 1, 2, 0, -1, 0));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd0, 0, 7, TG,  2, 1));
    tbl.push_back(mk(3'd1, 0, 4, TY, -1, 1));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 1));
    tbl.push_back(mk(3'd5, 0, 2, TW, -1, 0));
    run_tbl();

    // emergency during walk: walk drops on the next cycle
    emerg = 1'b1;
    tbl.push_back(mk(3'd5, 2, 3, TW, -1, 0));
    tbl.push_back(mk(3'd6, 0, 3, 0, -1, 0));
    run_tbl();
    emerg = 1'b0;
    tbl.push_back(mk(3'd6, 3, 4, 0, -1, 0));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd2, 0, 7, TG, -1, 0));
    tbl.push_back(mk(3'd3, 0, 4, TY, -1, 0));
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd0, 0, 7, TG,  1, 1));
    tbl.push_back(mk(3'd1, 0, 2, TY, -1, 1));
    run_tbl();

    // one-cycle reset in the middle of NS yellow
    reset = 1'b1;
    tbl.push_back(mk(3'd1, 2, 3, TY, -1, 1));
    run_tbl();
    reset = 1'b0;
    tbl.push_back(mk(3'd4, 0, 3, TA, -1, 0));
    tbl.push_back(mk(3'd0, 0, 7, TG, -1, 0));
    tbl.push_back(mk(3'd1, 0, 1, TY, -1, 0));
    run_tbl();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
